mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: MEM_Stage

---
 rtl/mem_stage.sv | 168 ++++++++++++++++
 tb/tb_mem_stage.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: data-memory stage of a pipelined core with a fixed-latency access.
// A small IDLE/BUSY/DONE controller holds `ready` low for exactly WAIT_CYCLES
// cycles per load/store. The word array is written, or read into a registered
// result, only at the single "access edge" at the end of that window.
// The optional address checker is built when the macro MEM_ALIGN_CHECK_EN is
// defined. Without it, the word index wraps modulo DEPTH and mem_fault stays 0.
module mem_stage #(
    parameter int          WAIT_CYCLES = 4,
    parameter int          DEPTH       = 64,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALU_result,
    input  logic [31:0] Val_Rm,
    output logic [31:0] MEM_result,
    output logic        ready,
    output logic        mem_fault
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [3:0]     r_cnt;
    logic [3:0]     w_cnt_next;
    logic           w_access;
    logic           w_ready;

    logic           w_req;
    logic           w_store;
    logic           w_load;
    logic [31:0]    w_offset;
    logic [AW-1:0]  w_index;
    logic           w_fault;

    logic [31:0]    r_mem [DEPTH];
    logic [31:0]    r_result;

    // A store takes priority when both enables are raised together.
    assign w_req   = MEM_R_EN | MEM_W_EN;
    assign w_store = MEM_W_EN;
    assign w_load  = MEM_R_EN & ~MEM_W_EN;

    // Byte offset from the window base. The borrow is dropped, so addresses
    // below the base simply wrap around.
    assign w_offset = ALU_result - BASE_ADDR;
    assign w_index  = w_offset[AW+1:2];

`ifdef MEM_ALIGN_CHECK_EN
    // Upper bound is computed in 33 bits so that a window ending at 2^32
    // does not overflow.
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

    logic w_misaligned;
    logic w_below;
    logic w_above;
    logic r_fault;

    assign w_misaligned = |ALU_result[1:0];
    assign w_below      = ALU_result < BASE_ADDR;
    assign w_above      = {1'b0, ALU_result} >= LIMIT;
    assign w_fault      = w_misaligned | w_below | w_above;

    // Fault flag captured at the access edge; shown only while in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (w_access) begin
            r_fault <= w_fault;
        end
    end

    assign mem_fault = (r_state == DONE) & r_fault;
`else
    assign w_fault   = 1'b0;
    assign mem_fault = 1'b0;
`endif

    // Offset bits outside the word index play no part in addressing.
    logic w_unused_offset;
    assign w_unused_offset = ^{w_offset[31:AW+2], w_offset[1:0]};

    // State register and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state, counter and handshake decode.
    // The IDLE cycle in which a request appears is the first low cycle.
    // BUSY then covers the remaining WAIT_CYCLES-1 cycles. The access fires
    // on the BUSY edge at which the counter steps down to zero.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_access     = 1'b0;
        w_ready      = 1'b1;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_ready = 1'b0;
                    if (WAIT_CYCLES == 1) begin
                        w_access     = 1'b1;
                        w_state_next = DONE;
                    end else begin
                        w_cnt_next   = CNT_INIT;
                        w_state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                w_ready    = 1'b0;
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_cnt_next   = 4'd0;
                    w_access     = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // Reset overrides the handshake so that upstream never stalls on reset.
    assign ready = rst | w_ready;

    // Word array write port. The array is deliberately left uninitialised by
    // reset. A reset landing on the access edge cancels the store.
    always_ff @(posedge clk) begin
        if (!rst && w_access && w_store && !w_fault) begin
            r_mem[w_index] <= Val_Rm;
        end
    end

    // Registered read port. The result changes only on a load access edge.
    // A faulting load returns zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= 32'd0;
        end else if (w_access && w_load) begin
            r_result <= w_fault ? 32'd0 : r_mem[w_index];
        end
    end

    assign MEM_result = r_result;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage.
// The reference model is a plain word array indexed by address arithmetic.
// A second instance is built with WAIT_CYCLES=1 for the single-cycle case.
module tb_mem_stage;

    localparam int          WAIT  = 4;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'd1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_en, w_en;
    logic [31:0] addr, wdata;
    logic [31:0] result;
    logic        ready, fault;

    logic        r1_en, w1_en;
    logic [31:0] addr1, wdata1;
    logic [31:0] result1;
    logic        ready1, fault1;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_result;

    always #5 clk = ~clk;

    mem_stage #(.WAIT_CYCLES(WAIT), .DEPTH(DEPTH), .BASE_ADDR(BASE)) u_dut (
        .clk(clk), .rst(rst), .MEM_R_EN(r_en), .MEM_W_EN(w_en),
        .ALU_result(addr), .Val_Rm(wdata),
        .MEM_result(result), .ready(ready), .mem_fault(fault)
    );

    mem_stage #(.WAIT_CYCLES(1), .DEPTH(DEPTH), .BASE_ADDR(BASE)) u_dut1 (
        .clk(clk), .rst(rst), .MEM_R_EN(r1_en), .MEM_W_EN(w1_en),
        .ALU_result(addr1), .Val_Rm(wdata1),
        .MEM_result(result1), .ready(ready1), .mem_fault(fault1)
    );

    function automatic int idx_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off >> 2) % DEPTH);
    endfunction

    function automatic bit fault_of(input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        logic [32:0] lim;
        lim = {1'b0, BASE} + 33'(4 * DEPTH);
        return (a[1:0] != 2'b00) || (a < BASE) || ({1'b0, a} >= lim);
`else
        return (a === 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    // One complete access on the default instance; called just after a rising edge.
    task automatic access(input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input string tag);
        int  low;
        bit  done;
        bit  f;
        r_en  = r;
        w_en  = w;
        addr  = a;
        wdata = d;
        f     = fault_of(a);
        if (w) begin
            if (!f) model_mem[idx_of(a)] = d;
        end else if (r) begin
            exp_result = f ? 32'd0 : model_mem[idx_of(a)];
        end
        low  = 0;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                done = 1;
            end else begin
                low++;
                total++;
                if (fault !== 1'b0) begin
                    bad++;
                    $display("FAIL %s fault_while_busy: got %b expected 0", tag, fault);
                end
            end
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s timeout: ready stuck low after %0d cycles, expected high", tag, low);
        end
        total++;
        if (low !== WAIT) begin
            bad++;
            $display("FAIL %s latency: got %0d low cycles expected %0d", tag, low, WAIT);
        end
        total++;
        if (result !== exp_result) begin
            bad++;
            $display("FAIL %s result: got %h expected %h", tag, result, exp_result);
        end
        total++;
        if (fault !== f) begin
            bad++;
            $display("FAIL %s mem_fault: got %b expected %b", tag, fault, f);
        end
        $display("txn %s r=%0b w=%0b addr=%h data=%h result=%h fault=%0b low=%0d",
                 tag, r, w, a, d, result, fault, low);
        @(posedge clk);
        #1;
        r_en = 1'b0;
        w_en = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input string tag);
        r_en  = 1'b0;
        w_en  = 1'b0;
        addr  = $urandom;
        wdata = $urandom;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            total++;
            if (ready !== 1'b1) begin
                bad++;
                $display("FAIL %s idle_ready: got %b expected 1", tag, ready);
            end
            total++;
            if (result !== exp_result) begin
                bad++;
                $display("FAIL %s idle_result: got %h expected %h", tag, result, exp_result);
            end
            $display("txn %s idle cycle=%0d ready=%0b result=%h", tag, i, ready, result);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        r_en = 1'b1; w_en = 1'b1; addr = BASE; wdata = 32'hFFFF_FFFF;
        r1_en = 1'b0; w1_en = 1'b0; addr1 = BASE; wdata1 = 32'd0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL reset ready_during_rst: got %b expected 1", ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; r_en = 1'b0; w_en = 1'b0;
        exp_result = 32'd0;
        @(negedge clk);
        total++;
        if (result !== 32'd0) begin
            bad++;
            $display("FAIL reset result: got %h expected 0", result);
        end
        total++;
        if (fault !== 1'b0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL reset flags: got fault=%b ready=%b expected 0/1", fault, ready);
        end
        $display("txn reset ready=%0b result=%h fault=%0b", ready, result, fault);
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            access(1'b0, 1'b1, BASE + 32'(4 * i), $urandom, "fill");
        end
    endtask

    task automatic test_store_load();
        access(1'b0, 1'b1, BASE, 32'hDEAD_BEEF, "st_deadbeef");
        access(1'b1, 1'b0, BASE, 32'd0, "ld_deadbeef");
        total++;
        if (result !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL ld_deadbeef const: got %h expected deadbeef", result);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int i = 0; i < 6; i++) begin
            a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            access(1'b0, 1'b1, a, $urandom, "b2b_st");
            access(1'b1, 1'b0, a, 32'd0, "b2b_ld");
        end
        // Both enables high behaves as a store and leaves the result alone.
        access(1'b1, 1'b1, BASE + 32'd8, 32'h0BAD_F00D, "both_st");
        access(1'b1, 1'b0, BASE + 32'd8, 32'd0, "both_ld");
    endtask

    task automatic test_reset_mid();
        access(1'b0, 1'b1, BASE + 32'd8, 32'd0, "rm_pre");
        r_en = 1'b0; w_en = 1'b1; addr = BASE + 32'd8; wdata = 32'h1234;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; w_en = 1'b0;
        exp_result = 32'd0;
        @(negedge clk);
        total++;
        if (ready !== 1'b1 || result !== 32'd0) begin
            bad++;
            $display("FAIL rm_after: got ready=%b result=%h expected 1/0", ready, result);
        end
        $display("txn rm_abort ready=%0b result=%h", ready, result);
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, BASE + 32'd8, 32'd0, "rm_ld");
        total++;
        if (result === 32'h1234) begin
            bad++;
            $display("FAIL rm_ld abandoned_write: got %h expected 00000000", result);
        end
    endtask

    task automatic test_addr_edges();
`ifdef MEM_ALIGN_CHECK_EN
        access(1'b0, 1'b1, BASE + 32'd2, 32'h7777, "chk_misalign_st");
        access(1'b1, 1'b0, BASE, 32'd0, "chk_nowrite_ld");
        access(1'b1, 1'b0, BASE + 32'(4 * DEPTH), 32'd0, "chk_high_ld");
        access(1'b1, 1'b0, BASE - 32'd4, 32'd0, "chk_low_ld");
`else
        access(1'b0, 1'b1, BASE + 32'(4 * DEPTH), 32'hA, "wrap_st");
        access(1'b1, 1'b0, BASE, 32'd0, "wrap_ld");
        total++;
        if (result !== 32'hA) begin
            bad++;
            $display("FAIL wrap_ld const: got %h expected 0000000a", result);
        end
        access(1'b0, 1'b1, BASE + 32'd23, 32'h5A5A, "lowbits_st");
        access(1'b1, 1'b0, BASE + 32'd20, 32'd0, "lowbits_ld");
`endif
    endtask

    task automatic test_random();
        logic [31:0] a;
        bit          r, w;
        int          gap;
        for (int i = 0; i < 60; i++) begin
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            if (!r && !w) r = 1'b1;
            if ($urandom_range(0, 3) == 0)
                a = BASE - 32'd64 + 32'($urandom_range(0, 4 * DEPTH + 127));
            else
                a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            access(r, w, a, $urandom, "rand");
            gap = $urandom_range(0, 2);
            if (gap != 0) idle_cycles(gap, "rand_gap");
        end
    endtask

    task automatic test_wait1();
        bit exp_pat [4];
        bit got_pat [4];
        exp_pat[0] = 1'b0; exp_pat[1] = 1'b1; exp_pat[2] = 1'b0; exp_pat[3] = 1'b1;
        w1_en = 1'b1; r1_en = 1'b0; addr1 = BASE + 32'd4; wdata1 = 32'h5;
        @(negedge clk); got_pat[0] = ready1;
        @(posedge clk); #1;
        @(negedge clk); got_pat[1] = ready1;
        total++;
        if (result1 !== 32'd0 || fault1 !== 1'b0) begin
            bad++;
            $display("FAIL w1_st_done: got result=%h fault=%b expected 0/0", result1, fault1);
        end
        @(posedge clk); #1;
        w1_en = 1'b0; r1_en = 1'b1;
        @(negedge clk); got_pat[2] = ready1;
        @(posedge clk); #1;
        @(negedge clk); got_pat[3] = ready1;
        total++;
        if (result1 !== 32'h5) begin
            bad++;
            $display("FAIL w1_ld result: got %h expected 00000005", result1);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_pat[i] !== exp_pat[i]) begin
                bad++;
                $display("FAIL w1_ready[%0d]: got %b expected %b", i, got_pat[i], exp_pat[i]);
            end
        end
        $display("txn wait1 ready=%0b%0b%0b%0b result=%h",
                 got_pat[0], got_pat[1], got_pat[2], got_pat[3], result1);
        @(posedge clk); #1;
        r1_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wait1();
        test_fill();
        test_store_load();
        idle_cycles(10, "no_mem_op");
        test_back_to_back();
        test_addr_edges();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
